// File: rtl/ysyx_22051013_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
// Holds widths, opcodes, the default reset PC and the fetch FSM states.
package ysyx_22051013_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC = 64'h8000_0000;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22051013_bpu_static.sv
// Static branch predictor: JAL and backward branches are taken.
// Ports: inst/pc in; taken and 64-bit wrapping target out (else pc+4).
module ysyx_22051013_bpu_static
  import ysyx_22051013_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  input  logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic [PC_W-1:0]   target
);

  logic [6:0]      opcode;
  logic [PC_W-1:0] j_imm;
  logic [PC_W-1:0] b_imm;

  assign opcode = inst[6:0];

  assign j_imm = {{44{inst[31]}}, inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  assign b_imm = {{52{inst[31]}}, inst[7],
                  inst[30:25], inst[11:8], 1'b0};

  always_comb begin
    taken  = 1'b0;
    target = pc + 64'd4;
    unique case (1'b1)
      (opcode == OP_JAL): begin
        taken  = 1'b1;
        target = pc + j_imm;
      end
      // sign bit of the B-immediate marks a backward branch
      (opcode == OP_BRANCH) && inst[31]: begin
        taken  = 1'b1;
        target = pc + b_imm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_ifu.sv
// Instruction fetch unit: PC owner, single-outstanding imem fetch FSM.
// Ports: imem req/gnt/rvalid, redirect in, IF/ID outputs + busy hold.
module ysyx_22051013_ifu
  import ysyx_22051013_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              id_stall,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic              bpu_jump,
  output logic              if_busy
);

  ifu_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] npc_q;
  logic            drop_q, drop_d;
  logic            cap;
  logic            clr_jump;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  // predict on the word being captured; target kept for consumption
  ysyx_22051013_bpu_static u_bpu (
    .inst   (imem_rdata),
    .pc     (pc_q),
    .taken  (pred_taken),
    .target (pred_target)
  );

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_busy   = (state_q != S_READY);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    cap      = 1'b0;
    clr_jump = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_gnt) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // a response in this same cycle is the stale one
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q) begin
            state_d = S_REQ;
          end else begin
            cap     = 1'b1;
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          clr_jump = 1'b1;
          state_d  = S_REQ;
        end else if (!id_stall) begin
          pc_d    = npc_q;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      npc_q    <= '0;
      if_inst  <= '0;
      if_pc    <= '0;
      bpu_jump <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (cap) begin
        if_inst  <= imem_rdata;
        if_pc    <= pc_q;
        bpu_jump <= pred_taken;
        npc_q    <= pred_target;
      end else if (clr_jump) begin
        bpu_jump <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_ifu.sv
// Self-checking bench for ysyx_22051013_ifu.
// Table vectors, hand sequences and a randomized run against a model.
module tb_ysyx_22051013_ifu;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        bpu_jump;
  logic        if_busy;

  localparam logic [63:0] RPC = 64'h8000_0000;

  ysyx_22051013_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .bpu_jump       (bpu_jump),
    .if_busy        (if_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- program image model ----------------
  typedef struct {
    logic [31:0] inst;
    logic        jump;
    logic [63:0] nxt;
  } ent_t;

  function automatic logic [31:0] enc_j(logic [20:0] i);
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] i);
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000,
            i[4:1], i[11], 7'b1100011};
  endfunction

  // instruction kind and offset chosen from the address; the expected
  // successor comes from the offset chosen, not from decoding the word
  function automatic ent_t gen(logic [63:0] a);
    ent_t e;
    logic signed [63:0] off;
    int k;
    k = (int'(a[4:2]) + int'(a[9:7])) % 5;
    e.jump = 1'b0;
    e.nxt  = a + 64'd4;
    case (k)
      1: begin
        off = 64'((int'(a[6:3]) - 8) * 4);
        e.inst = enc_j(off[20:0]);
        e.jump = 1'b1;
        e.nxt  = a + off;
      end
      2: begin
        off = -64'(4 * (1 + int'(a[6:3])));
        e.inst = enc_b(off[12:0]);
        e.jump = 1'b1;
        e.nxt  = a + off;
      end
      3: begin
        off = 64'(4 * (1 + int'(a[6:3])));
        e.inst = enc_b(off[12:0]);
      end
      4: e.inst = 32'h000080e7;
      default: e.inst = {a[13:2], 5'd0, 3'd0, 5'd1, 7'b0010011};
    endcase
    return e;
  endfunction

  logic        ov_en = 1'b0;
  logic [63:0] ov_addr = '0;
  logic [31:0] ov_inst = '0;

  function automatic ent_t look(logic [63:0] a);
    ent_t e;
    e = gen(a);
    if (ov_en && a == ov_addr) e.inst = ov_inst;
    return e;
  endfunction

  // ---------------- memory model ----------------
  logic        auto_mem = 1'b1;
  int          gnt_pct = 100;
  int          max_lat = 0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        h_gnt = 1'b0, h_rvalid = 1'b0;
  logic [31:0] h_rdata = '0;

  assign imem_gnt    = auto_mem ? m_gnt : h_gnt;
  assign imem_rvalid = auto_mem ? m_rvalid : h_rvalid;
  assign imem_rdata  = auto_mem ? m_rdata : h_rdata;

  initial begin : mem
    logic        pend, fired;
    logic [63:0] paddr, faddr;
    int          wn;
    ent_t        e;
    pend = 0; fired = 0; paddr = '0; faddr = '0; wn = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !auto_mem) begin
        pend = 0; fired = 0;
        m_gnt = 0; m_rvalid = 0;
      end else begin
        if (m_rvalid) pend = 0;
        m_rvalid = 0;
        if (fired) begin
          pend  = 1;
          paddr = faddr;
          wn    = $urandom_range(0, max_lat);
        end
        fired = 0;
        if (pend) begin
          if (wn == 0) begin
            e = look(paddr);
            m_rvalid = 1;
            m_rdata  = e.inst;
          end else begin
            wn--;
          end
        end
        m_gnt = !pend && ($urandom_range(0, 99) < gnt_pct);
        if (m_gnt && imem_req) begin
          fired = 1;
          faddr = imem_addr;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    id_stall = 1'b0;
    h_gnt = 1'b0;
    h_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ready(string nm);
    int n;
    n = 0;
    while (if_busy && n < 200) begin
      tick();
      n++;
    end
    if (if_busy) begin
      nvec++;
      nerr++;
      $display("FAIL %s: no READY within 200 cycles", nm);
    end
  endtask

  task automatic mfetch(logic [31:0] w);
    h_gnt = 1'b1;
    tick();
    h_gnt = 1'b0;
    h_rvalid = 1'b1;
    h_rdata = w;
    tick();
    h_rvalid = 1'b0;
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        jump;
    logic [63:0] nxt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [63:0] exp_pc, spc;
    logic [31:0] sinst;
    ent_t e;
    int idle, cons;

    tbl[0] = '{64'h8000_0000, 32'h0100006f, 1'b1, 64'h8000_0010};
    tbl[1] = '{64'h8000_0008, 32'hfe000ee3, 1'b1, 64'h8000_0004};
    tbl[2] = '{64'h8000_0008, 32'h00000463, 1'b0, 64'h8000_000c};
    tbl[3] = '{64'h8000_0040, 32'h00000013, 1'b0, 64'h8000_0044};
    tbl[4] = '{64'h8000_0040, 32'h000080e7, 1'b0, 64'h8000_0044};
    tbl[5] = '{64'h0, 32'hff9ff0ef, 1'b1, 64'hffff_ffff_ffff_fff8};
    tbl[6] = '{64'h8000_0000, 32'h80000063, 1'b1, 64'h7fff_f000};
    tbl[7] = '{64'hffff_ffff_ffff_fffc, 32'h0100006f, 1'b1, 64'hc};
    tbl[8] = '{64'h8000_0010, 32'hfe209ee3, 1'b1, 64'h8000_000c};

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_stall = 1'b0;
    #3;
    chk("rst if_inst", 64'(if_inst), 64'h0);
    chk("rst if_pc", if_pc, 64'h0);
    chk("rst bpu_jump", 64'(bpu_jump), 64'h0);
    chk("rst if_busy", 64'(if_busy), 64'h1);

    // zero-wait first fetch: REQ, WAIT, READY
    ov_en = 1'b1;
    ov_addr = RPC;
    ov_inst = 32'h00000013;
    do_reset();
    chk("c1 req", 64'(imem_req), 64'h1);
    chk("c1 addr", imem_addr, RPC);
    chk("c1 busy", 64'(if_busy), 64'h1);
    tick();
    chk("c2 busy", 64'(if_busy), 64'h1);
    chk("c2 req", 64'(imem_req), 64'h0);
    tick();
    chk("c3 busy", 64'(if_busy), 64'h0);
    chk("c3 if_pc", if_pc, RPC);
    chk("c3 if_inst", 64'(if_inst), 64'h13);
    chk("c3 jump", 64'(bpu_jump), 64'h0);
    tick();
    chk("c4 req", 64'(imem_req), 64'h1);
    chk("c4 addr", imem_addr, RPC + 64'd4);

    // table vectors, zero-wait memory
    foreach (tbl[i]) begin
      wait_ready("tbl pre");
      ov_en = 1'b1;
      ov_addr = tbl[i].pc;
      ov_inst = tbl[i].inst;
      redirect_valid = 1'b1;
      redirect_pc = tbl[i].pc;
      tick();
      redirect_valid = 1'b0;
      chk("tbl redir busy", 64'(if_busy), 64'h1);
      chk("tbl redir jump", 64'(bpu_jump), 64'h0);
      wait_ready("tbl fetch");
      chk("tbl if_pc", if_pc, tbl[i].pc);
      chk("tbl if_inst", 64'(if_inst), 64'(tbl[i].inst));
      chk("tbl jump", 64'(bpu_jump), 64'(tbl[i].jump));
      tick();
      chk("tbl next req", 64'(imem_req), 64'h1);
      chk("tbl next addr", imem_addr, tbl[i].nxt);
    end

    // manual memory: stall hold
    auto_mem = 1'b0;
    do_reset();
    mfetch(32'h00000013);
    chk("stall ready", 64'(if_busy), 64'h0);
    spc = if_pc;
    sinst = if_inst;
    id_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall busy", 64'(if_busy), 64'h0);
      chk("stall req", 64'(imem_req), 64'h0);
      chk("stall pc", if_pc, spc);
      chk("stall inst", 64'(if_inst), 64'(sinst));
    end
    id_stall = 1'b0;
    tick();
    chk("release req", 64'(imem_req), 64'h1);
    chk("release addr", imem_addr, RPC + 64'd4);

    // redirect in WAIT, stale response two cycles later
    do_reset();
    h_gnt = 1'b1;
    tick();
    h_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("drop w1 busy", 64'(if_busy), 64'h1);
    tick();
    chk("drop w2 busy", 64'(if_busy), 64'h1);
    h_rvalid = 1'b1;
    h_rdata = 32'h0100006f;
    tick();
    h_rvalid = 1'b0;
    chk("drop busy", 64'(if_busy), 64'h1);
    chk("drop req", 64'(imem_req), 64'h1);
    chk("drop addr", imem_addr, 64'h8000_0100);
    mfetch(32'h00000013);
    chk("drop refetch busy", 64'(if_busy), 64'h0);
    chk("drop refetch pc", if_pc, 64'h8000_0100);
    chk("drop refetch jump", 64'(bpu_jump), 64'h0);

    // redirect and response in the same WAIT cycle
    do_reset();
    h_gnt = 1'b1;
    tick();
    h_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    h_rvalid = 1'b1;
    h_rdata = 32'h00000013;
    tick();
    redirect_valid = 1'b0;
    h_rvalid = 1'b0;
    chk("same busy", 64'(if_busy), 64'h1);
    chk("same req", 64'(imem_req), 64'h1);
    chk("same addr", imem_addr, 64'h8000_0100);
    mfetch(32'h0100006f);
    chk("same refetch busy", 64'(if_busy), 64'h0);
    chk("same refetch pc", if_pc, 64'h8000_0100);
    chk("same refetch jump", 64'(bpu_jump), 64'h1);

    // asynchronous reset in WAIT
    tick();
    h_gnt = 1'b1;
    tick();
    h_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst inst", 64'(if_inst), 64'h0);
    chk("arst pc", if_pc, 64'h0);
    chk("arst jump", 64'(bpu_jump), 64'h0);
    chk("arst busy", 64'(if_busy), 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("arst restart req", 64'(imem_req), 64'h1);
    chk("arst restart addr", imem_addr, RPC);

    // randomized run against the stream model
    auto_mem = 1'b1;
    ov_en = 1'b0;
    gnt_pct = 60;
    max_lat = 3;
    do_reset();
    exp_pc = RPC;
    idle = 0;
    cons = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!if_busy) begin
        e = look(exp_pc);
        chk("rnd if_pc", if_pc, exp_pc);
        chk("rnd if_inst", 64'(if_inst), 64'(e.inst));
        chk("rnd jump", 64'(bpu_jump), 64'(e.jump));
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 100) begin
        nvec++;
        nerr++;
        $display("FAIL rnd watchdog: busy for %0d cycles", idle);
        break;
      end
      id_stall = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 5);
      redirect_pc = RPC + 64'($urandom_range(0, 255) << 2);
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (!if_busy && !id_stall) begin
        exp_pc = look(exp_pc).nxt;
        cons++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    id_stall = 1'b0;
    nvec++;
    if (cons < 50) begin
      nerr++;
      $display("FAIL rnd progress: got %0d consumed expected >=50", cons);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
